// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM stage between EX and WB. Selects the data-memory address (ALU result,
// stack pointer, or stack pointer +/- SP_STEP), registers it for block-RAM
// setup timing and runs a single outstanding request/acknowledge handshake
// with the memory controller. Loads wait RD_LAT cycles after acceptance and
// then capture the read data. Push/pop ops also return the updated stack
// pointer. The pipeline is stalled from the cycle an op is accepted until the
// access completes.
//
// Parameters
//   ADDR_W   address / stack-pointer width
//   DATA_W   memory data width
//   RD_LAT   cycles from accepted read to valid mem_rdata (>= 1)
//   SP_STEP  byte step applied to SP on push/pop
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   MEM-stage op present (sampled only in IDLE)
//   in_re      in   op is a load
//   in_we      in   op is a store (re & we together is treated as a store)
//   addr_mode  in   0=ALU, 1=SP, 2=push (SP-SP_STEP), 3=pop (SP, SP+SP_STEP)
//   alu_out    in   ALU-computed address
//   sp_out     in   current stack pointer
//   wr_data    in   store data
//   mem_addr   out  registered address to controller
//   mem_re     out  read request, held until mem_ready
//   mem_we     out  write request, held until mem_ready
//   mem_wdata  out  registered store data
//   mem_ready  in   controller accepts request this cycle
//   mem_rdata  in   read data, valid RD_LAT cycles after acceptance
//   ld_data    out  captured load data, held until the next load completes
//   ld_valid   out  1-cycle pulse: ld_data updated
//   sp_new     out  updated stack pointer (push/pop)
//   sp_wr      out  1-cycle pulse: write sp_new to SP
//   stall      out  pipeline must hold MEM-stage inputs
//
// States
//   IDLE | waiting for an op; accepts load/store or SP-only update
//   REQ  | request on the bus, waiting for mem_ready
//   WAIT | read accepted, counting down the read latency
//   DONE | access complete; ld_valid/sp_wr pulses, one-cycle bubble
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 2,
  parameter int SP_STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_re,
  input  logic              in_we,
  input  logic [1:0]        addr_mode,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [ADDR_W-1:0] sp_out,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic [ADDR_W-1:0] sp_new,
  output logic              sp_wr,
  output logic              stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Counter holds RD_LAT-1 at most; keep at least one bit for RD_LAT == 1.
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(SP_STEP);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_zero;
  logic              is_read_q;
  logic              sp_upd_q;

  logic              accept;
  logic              sp_only;
  logic              op_read;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sp_calc;

  // Request decode (only meaningful while IDLE)
  assign accept   = in_valid & (in_re | in_we);
  assign sp_only  = in_valid & ~in_re & ~in_we & addr_mode[1];
  // Store wins when both strobes are set.
  assign op_read  = in_re & ~in_we;
  assign cnt_zero = (cnt_q == '0);

  // Address select; arithmetic wraps modulo 2^ADDR_W.
  always_comb begin
    sel_addr = alu_out;
    case (addr_mode)
      2'd0:    sel_addr = alu_out;
      2'd1:    sel_addr = sp_out;
      2'd2:    sel_addr = sp_out - STEP;
      2'd3:    sel_addr = sp_out;
      default: sel_addr = alu_out;
    endcase
  end

  // Push pre-decrements, pop post-increments.
  assign sp_calc = addr_mode[0] ? (sp_out + STEP) : (sp_out - STEP);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d = is_read_q ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        if (cnt_zero) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs: stall rises combinationally in the accepting IDLE cycle so
  // EX holds its operands without a cycle of slip.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_IDLE:  stall = accept;
      S_REQ:   stall = 1'b1;
      S_WAIT:  stall = 1'b1;
      S_DONE:  stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Request side: address, data and strobes are captured once in IDLE and
  // held untouched until the controller acknowledges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      is_read_q <= 1'b0;
      sp_upd_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mem_addr  <= sel_addr;
            mem_wdata <= wr_data;
            mem_re    <= op_read;
            mem_we    <= in_we;
            is_read_q <= op_read;
            sp_upd_q  <= addr_mode[1];
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read-latency down-counter; loaded on acceptance of a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_REQ && mem_ready) begin
      cnt_q <= CNT_INIT;
    end else if (state_q == S_WAIT && !cnt_zero) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Completion side. ld_valid/sp_wr are registered so they coincide with
  // DONE (or the cycle after an SP-only update in IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_data  <= '0;
      ld_valid <= 1'b0;
      sp_new   <= '0;
      sp_wr    <= 1'b0;
    end else begin
      ld_valid <= 1'b0;
      sp_wr    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (addr_mode[1]) begin
              sp_new <= sp_calc;
            end
          end else if (sp_only) begin
            sp_new <= sp_calc;
            sp_wr  <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem_ready && !is_read_q) begin
            sp_wr <= sp_upd_q;
          end
        end
        S_WAIT: begin
          if (cnt_zero) begin
            ld_data  <= mem_rdata;
            ld_valid <= 1'b1;
            sp_wr    <= sp_upd_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
